// File: rtl/bus_uart_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_uart_xfer_pkg
//  Description : Shared definitions for the bus-to-UART transfer block:
//                FSM state encodings, grant/free active levels, bytes per
//                word, header source codes and the word_number width.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_uart_xfer_pkg;

    localparam int WORD_NUM_W     = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    // Active levels of the arbiter handshake lines
    localparam logic GRANT_ENABLE = 1'b1;
    localparam logic FREE_ENABLE  = 1'b1;

    // Transfer FSM encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        SEND = 3'd3,
        WAIT = 3'd4,
        DONE = 3'd5
    } xfer_state_t;

    // Latched source; the codes double as the header source field
    typedef enum logic [1:0] {
        SRC_NONE    = 2'b00,
        SRC_IO      = 2'b01,
        SRC_L2CACHE = 2'b10,
        SRC_UNCACHE = 2'b11
    } src_t;

    // Header byte layout: {source, 2'b00, word count}
    function automatic logic [7:0] header_byte(input src_t src,
                                               input logic [WORD_NUM_W-1:0] num);
        return {src, 2'b00, num};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_uart_xfer_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Holds the 32-bit shift register and byte counter and runs
//                the per-byte tx_start / tx_busy handshake. Bytes leave LSB
//                first. The controller tells it when it is in SEND/HDR
//                (start) and WAIT (in_wait); it reports byte and word done.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import bus_uart_xfer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_word,
    input  logic [31:0] word_data,
    input  logic        load_hdr,
    input  logic [7:0]  hdr_byte,
    input  logic        start,
    input  logic        in_wait,
    input  logic        hdr_mode,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        byte_done,
    output logic        word_done
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]           shift_q;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  guard;      // high during the first WAIT cycle

    assign tx_start  = start;
    assign tx_data   = shift_q[7:0];
    // The guard cycle gives the UART one edge to raise tx_busy
    assign byte_done = in_wait && !guard && !tx_busy;
    assign word_done = byte_done && !hdr_mode && (byte_cnt == LAST_BYTE);

    // Shift register, byte counter and guard flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_q  <= '0;
            byte_cnt <= '0;
            guard    <= 1'b0;
        end else begin
            guard <= start;
            if (load_word) begin
                shift_q  <= word_data;
                byte_cnt <= '0;
            end else if (load_hdr) begin
                shift_q  <= {24'h0, hdr_byte};
                byte_cnt <= '0;
            end else if (byte_done) begin
                shift_q <= shift_q >> 8;
                // Header bytes are not payload; the counter saturates at the last byte
                if (!hdr_mode && byte_cnt != LAST_BYTE) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_uart_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_uart_xfer
//  Description : Takes a granted bus master's word stream and sends it
//                byte-wise to a UART transmitter, then pulses the matching
//                bus-free line. Source priority io > L2cache > uncache.
//                Optional macro BUS_XFER_HEADER_EN adds a header byte
//                {src, 2'b00, word_number} ahead of the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_uart_xfer
    import bus_uart_xfer_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bus_io_grant,
    input  logic                  bus_L2cache_grant,
    input  logic                  bus_uncache_grant,
    input  logic [WORD_NUM_W-1:0] word_number,
    input  logic [31:0]           word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  io_bus_free,
    output logic                  L2cache_bus_free,
    output logic                  uncache_bus_free,
    output logic                  xfer_busy
);

    xfer_state_t           state, state_next;
    src_t                  src, grant_src;
    logic [WORD_NUM_W-1:0] word_cnt;
    logic                  any_grant;
    logic                  load_word, load_hdr, start, in_wait, word_dec;
    logic                  byte_done, word_done, in_hdr;

    // Priority decode of the arbiter grants
    always_comb begin
        grant_src = SRC_NONE;
        if (bus_io_grant == GRANT_ENABLE)           grant_src = SRC_IO;
        else if (bus_L2cache_grant == GRANT_ENABLE) grant_src = SRC_L2CACHE;
        else if (bus_uncache_grant == GRANT_ENABLE) grant_src = SRC_UNCACHE;
    end
    assign any_grant = (grant_src != SRC_NONE);

`ifdef BUS_XFER_HEADER_EN
    logic hdr_pending;
    // Marks that the byte in flight is the header, not payload
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hdr_pending <= 1'b0;
        end else if (state == IDLE && any_grant) begin
            hdr_pending <= 1'b1;
        end else if (byte_done) begin
            hdr_pending <= 1'b0;
        end
    end
    assign in_hdr = hdr_pending;
`else
    assign in_hdr = 1'b0;
`endif

    // State register, source latch and word counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            src      <= SRC_NONE;
            word_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_grant) begin
                src      <= grant_src;
                word_cnt <= word_number;
            end else if (word_dec && word_cnt != '0) begin
                word_cnt <= word_cnt - 1'b1;
            end
        end
    end

    // Next-state decode and per-state outputs
    always_comb begin
        state_next       = state;
        word_ready       = 1'b0;
        load_word        = 1'b0;
        load_hdr         = 1'b0;
        start            = 1'b0;
        in_wait          = 1'b0;
        word_dec         = 1'b0;
        io_bus_free      = ~FREE_ENABLE;
        L2cache_bus_free = ~FREE_ENABLE;
        uncache_bus_free = ~FREE_ENABLE;
        case (state)
            IDLE: begin
                if (any_grant) begin
`ifdef BUS_XFER_HEADER_EN
                    load_hdr   = 1'b1;
                    state_next = HDR;
`else
                    state_next = (word_number == '0) ? DONE : LOAD;
`endif
                end
            end
`ifdef BUS_XFER_HEADER_EN
            HDR: begin
                start      = 1'b1;
                state_next = WAIT;
            end
`endif
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    load_word  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                start      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                in_wait = 1'b1;
                if (byte_done) begin
                    if (in_hdr) begin
                        state_next = (word_cnt == '0) ? DONE : LOAD;
                    end else if (word_done) begin
                        word_dec   = 1'b1;
                        state_next = (word_cnt == WORD_NUM_W'(1)) ? DONE : LOAD;
                    end else begin
                        state_next = SEND;
                    end
                end
            end
            DONE: begin
                if (src == SRC_IO)      io_bus_free      = FREE_ENABLE;
                if (src == SRC_L2CACHE) L2cache_bus_free = FREE_ENABLE;
                if (src == SRC_UNCACHE) uncache_bus_free = FREE_ENABLE;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign xfer_busy = (state != IDLE);

    word_serializer u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .load_word (load_word),
        .word_data (word_data),
        .load_hdr  (load_hdr),
        .hdr_byte  (header_byte(grant_src, word_number)),
        .start     (start),
        .in_wait   (in_wait),
        .hdr_mode  (in_hdr),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .byte_done (byte_done),
        .word_done (word_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_uart_xfer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_uart_xfer
//  Description : Self-checking bench for bus_uart_xfer. A table of transfer
//                records is replayed through a cycle-level driver/monitor;
//                reset-abort is a hand-written sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_uart_xfer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        bus_io_grant, bus_L2cache_grant, bus_uncache_grant;
    logic [3:0]  word_number;
    logic [31:0] word_data;
    logic        word_valid, word_ready;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy;
    logic        io_bus_free, L2cache_bus_free, uncache_bus_free;
    logic        xfer_busy;

    always #5 clk = ~clk;

    bus_uart_xfer dut (
        .clk               (clk),
        .resetn            (resetn),
        .bus_io_grant      (bus_io_grant),
        .bus_L2cache_grant (bus_L2cache_grant),
        .bus_uncache_grant (bus_uncache_grant),
        .word_number       (word_number),
        .word_data         (word_data),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .tx_data           (tx_data),
        .tx_start          (tx_start),
        .tx_busy           (tx_busy),
        .io_bus_free       (io_bus_free),
        .L2cache_bus_free  (L2cache_bus_free),
        .uncache_bus_free  (uncache_bus_free),
        .xfer_busy         (xfer_busy)
    );

    // grants = {uncache, L2cache, io}; exp_free uses the same bit order
    typedef struct {
        logic [2:0]  grants;
        logic [3:0]  wn;
        logic [31:0] base;
        int          busy;
        int          gap_word;
        int          gap_len;
        logic [2:0]  exp_free;
    } vec_t;

    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'h04040404;
    endfunction

    task automatic run_xfer(input vec_t v, input int id);
        logic [7:0]  got[$];
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        logic [2:0]  free_val = 3'b000;
        logic [1:0]  sc;
        int hdr_off = 0, cyc = 0, last_start = 0, left = 0;
        int widx = 0, gap_cnt = 0, pi, exp_per;
        bit free_seen = 0, finished = 0;

        sc = v.grants[0] ? 2'b01 : (v.grants[1] ? 2'b10 : 2'b11);
`ifdef BUS_XFER_HEADER_EN
        exp_q.push_back({sc, 2'b00, v.wn});
        hdr_off = 1;
`endif
        for (int k = 0; k < int'(v.wn); k++) begin
            w = word_of(v.base, k);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
        exp_per = (v.busy + 2 > 3) ? v.busy + 2 : 3;

        @(negedge clk);
        {bus_uncache_grant, bus_L2cache_grant, bus_io_grant} = v.grants;
        word_number = v.wn;

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (xfer_busy) {bus_uncache_grant, bus_L2cache_grant, bus_io_grant} = 3'b000;
            // UART model: busy rises the cycle after tx_start, for v.busy cycles
            tx_busy = (left > 0);
            if (left > 0) left--;
            if (tx_start) begin
                got.push_back(tx_data);
                pi = got.size() - 1 - hdr_off;
                if (pi > 0 && (pi % 4) != 0)
                    check($sformatf("v%0d_period_b%0d", id, pi), 32'(cyc - last_start), 32'(exp_per));
                last_start = cyc;
                left = v.busy;
            end
            if (free_seen) begin
                check($sformatf("v%0d_free_single", id),
                      32'({uncache_bus_free, L2cache_bus_free, io_bus_free}), 32'd0);
                check($sformatf("v%0d_idle_after", id), 32'(xfer_busy), 32'd0);
                finished = 1;
            end else if ({uncache_bus_free, L2cache_bus_free, io_bus_free} != 3'b000) begin
                free_seen = 1;
                free_val  = {uncache_bus_free, L2cache_bus_free, io_bus_free};
            end
            if (word_ready) begin
                if (widx == v.gap_word && gap_cnt < v.gap_len) begin
                    word_valid = 1'b0;
                    gap_cnt++;
                    check($sformatf("v%0d_gap_no_start", id), 32'(tx_start), 32'd0);
                end else begin
                    word_valid = 1'b1;
                    word_data  = word_of(v.base, widx);
                    widx++;
                end
            end else begin
                word_valid = 1'b0;
            end
        end
        word_valid = 1'b0;
        tx_busy    = 1'b0;

        check($sformatf("v%0d_timeout", id), 32'(finished), 32'd1);
        check($sformatf("v%0d_nbytes", id), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("v%0d_byte%0d", id, i), 32'(got[i]), 32'(exp_q[i]));
        check($sformatf("v%0d_free_src", id), 32'(free_val), 32'(v.exp_free));
        if (v.gap_len > 0) check($sformatf("v%0d_gap_len", id), 32'(gap_cnt), 32'(v.gap_len));
    endtask

    // Abort in the middle of a word: outputs clear next cycle, no free afterwards
    task automatic reset_abort();
        int starts = 0, cyc = 0;
        int frees = 0, busies = 0;
        @(negedge clk);
        bus_io_grant = 1'b1;
        word_number  = 4'd1;
        while (starts < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (xfer_busy) bus_io_grant = 1'b0;
            if (tx_start) starts++;
            word_valid = word_ready;
            word_data  = 32'h44332211;
        end
        check("rst_reach_byte2", 32'(starts), 32'd2);
        check("rst_byte2_data", 32'(tx_data), 32'h22);
        resetn       = 1'b0;
        bus_io_grant = 1'b0;
        word_valid   = 1'b0;
        @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        check("rst_frees", 32'({uncache_bus_free, L2cache_bus_free, io_bus_free}), 32'd0);
        check("rst_xfer_busy", 32'(xfer_busy), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ({uncache_bus_free, L2cache_bus_free, io_bus_free} != 3'b000) frees++;
            if (xfer_busy) busies++;
        end
        check("rst_no_free_after", 32'(frees), 32'd0);
        check("rst_stays_idle", 32'(busies), 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'b001, 4'd1,  32'h44332211, 3, -1, 0, 3'b001};  // basic io word
        vecs[1] = '{3'b011, 4'd2,  32'hA5A55A5A, 1, -1, 0, 3'b001};  // io beats L2cache
        vecs[2] = '{3'b010, 4'd8,  32'h03020100, 0,  3, 5, 3'b010};  // valid gap before word 3
        vecs[3] = '{3'b100, 4'd0,  32'h00000000, 0, -1, 0, 3'b100};  // empty transfer
        vecs[4] = '{3'b100, 4'd3,  32'hDEADBEEF, 0, -1, 0, 3'b100};  // 3-cycle byte period
        vecs[5] = '{3'b110, 4'd15, 32'h87654321, 2, -1, 0, 3'b010};  // max words, L2 beats uncache

        resetn = 1'b0;
        {bus_uncache_grant, bus_L2cache_grant, bus_io_grant} = 3'b000;
        word_number = 4'd0;
        word_data   = 32'd0;
        word_valid  = 1'b0;
        tx_busy     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_start", 32'(tx_start), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        check("reset_word_ready", 32'(word_ready), 32'd0);
        check("reset_frees", 32'({uncache_bus_free, L2cache_bus_free, io_bus_free}), 32'd0);
        check("reset_xfer_busy", 32'(xfer_busy), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], i);
        reset_abort();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
